// File: rtl/ip_seq_pkg.sv
// Shared types and constants for the instruction-pointer sequencer.
package ip_seq_pkg;

   localparam int unsigned ADDR_W          = 8;
   localparam int unsigned STACK_DEPTH_DEF = 4;

   localparam logic OPSEL_INC  = 1'b0;
   localparam logic OPSEL_LOAD = 1'b1;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   // 8-bit wrap-around successor address.
   function automatic addr_t next_addr(input addr_t a);
      return a + addr_t'(1);
   endfunction

endpackage

// File: rtl/ip_sequencer_ret_stack.sv
// Return-address LIFO: one push or pop per cycle, top is the most recent entry.
module ret_stack
   import ip_seq_pkg::*;
#(
   parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  logic  pop,
   input  addr_t din,
   output addr_t top,
   output logic  full,
   output logic  empty
);

   localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SP_W = IW + 1;

   logic [SP_W-1:0] sp;
   addr_t           mem [DEPTH];
   logic [IW-1:0]   wr_idx;
   logic [IW-1:0]   rd_idx;

   assign wr_idx = sp[IW-1:0];
   assign rd_idx = IW'(sp - SP_W'(1));
   assign full   = (sp == SP_W'(DEPTH));
   assign empty  = (sp == '0);
   assign top    = empty ? '0 : mem[rd_idx];

   // Stack pointer and storage; pop wins if both are requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (pop && !empty) begin
         sp <= sp - SP_W'(1);
      end else if (push && !full) begin
         mem[wr_idx] <= din;
         sp          <= sp + SP_W'(1);
      end
   end

endmodule

// File: rtl/ip_sequencer.sv
// Instruction-pointer sequencer: fetch handshake, branch/call/return decision,
// IP register update strobe and return-address stack with fault halting.
module ip_sequencer
   import ip_seq_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic       mem_req,
   input  logic       mem_ready,
   output logic       instr_valid,
   input  logic       dec_done,
   input  logic       br_take,
   input  logic [7:0] br_target,
   input  logic       call,
   input  logic       ret,
   input  logic [7:0] ip_cur,
   output logic       ip_enable,
   output logic       ip_opsel,
   output logic [7:0] ip_load,
   output logic       halted,
   output logic       stk_ovf,
   output logic       stk_unf
);

   state_t state;
   state_t state_nxt;

   logic  accept;
   logic  exec_done;
   logic  sel_ret;
   logic  sel_call;
   logic  sel_br;
   logic  ovf_hit;
   logic  unf_hit;
   logic  stk_full;
   logic  stk_empty;
   addr_t stk_top;

   logic  dec_opsel;
   addr_t dec_load;

   logic  mem_req_d;
   logic  instr_valid_d;
   logic  ip_enable_d;
   logic  ip_opsel_d;
   addr_t ip_load_d;
   logic  halted_d;
   logic  stk_ovf_d;
   logic  stk_unf_d;

   assign accept    = (state == ST_FETCH) && mem_req && mem_ready;
   assign exec_done = (state == ST_EXEC) && dec_done;
   assign sel_ret   = exec_done && ret;
   assign sel_call  = exec_done && !ret && call;
   assign sel_br    = exec_done && !ret && !call && br_take;
   assign ovf_hit   = sel_call && stk_full;
   assign unf_hit   = sel_ret && stk_empty;

   ret_stack #(
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (sel_call && !stk_full),
      .pop   (sel_ret && !stk_empty),
      .din   (next_addr(ip_cur)),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection; stack faults divert EXEC straight to HALT.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   state_nxt = run ? ST_FETCH : ST_IDLE;
         ST_FETCH:  state_nxt = accept ? ST_EXEC : ST_FETCH;
         ST_EXEC: begin
            if (dec_done) begin
               state_nxt = (ovf_hit || unf_hit) ? ST_HALT : ST_UPDATE;
            end
         end
         ST_UPDATE: state_nxt = run ? ST_FETCH : ST_IDLE;
         ST_HALT:   state_nxt = ST_HALT;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Latch the winning decision when the decoder reports completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_opsel <= OPSEL_INC;
         dec_load  <= '0;
      end else if (exec_done) begin
         dec_opsel <= (sel_ret || sel_call || sel_br) ? OPSEL_LOAD : OPSEL_INC;
         if (sel_ret) begin
            dec_load <= stk_top;
         end else if (sel_call || sel_br) begin
            dec_load <= br_target;
         end else begin
            dec_load <= '0;
         end
      end
   end

   // Output next values. Outputs lag the state by one register stage, so
   // ip_enable lands one cycle after UPDATE is entered and a re-fetch from
   // UPDATE only raises mem_req once the IP register has taken the new value;
   // mem_req is cleared on the accepting edge to avoid an extra request cycle.
   always_comb begin
      mem_req_d     = (state == ST_FETCH) && !accept;
      instr_valid_d = accept;
      ip_enable_d   = (state == ST_UPDATE);
      ip_opsel_d    = ip_opsel;
      ip_load_d     = ip_load;
      if (state == ST_UPDATE) begin
         ip_opsel_d = dec_opsel;
         ip_load_d  = dec_load;
      end
      halted_d  = (state_nxt == ST_HALT);
      stk_ovf_d = stk_ovf || ovf_hit;
      stk_unf_d = stk_unf || unf_hit;
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req     <= 1'b0;
         instr_valid <= 1'b0;
         ip_enable   <= 1'b0;
         ip_opsel    <= 1'b0;
         ip_load     <= '0;
         halted      <= 1'b0;
         stk_ovf     <= 1'b0;
         stk_unf     <= 1'b0;
      end else begin
         mem_req     <= mem_req_d;
         instr_valid <= instr_valid_d;
         ip_enable   <= ip_enable_d;
         ip_opsel    <= ip_opsel_d;
         ip_load     <= ip_load_d;
         halted      <= halted_d;
         stk_ovf     <= stk_ovf_d;
         stk_unf     <= stk_unf_d;
      end
   end

endmodule
